bcd_to_seg: RTL and testbench



---
 rtl/bcd_seg_pkg.sv | 60 ++++++
 rtl/byte_to_bcd_conv.sv | 26 ++
 rtl/bcd_to_seg.sv | 65 ++++++
 tb/tb_bcd_to_seg.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// Shared glyphs, digit-select encodings and the nibble-to-segment helper for bcd_to_seg.
// Build option: define HEX_GLYPH_EN to show nibbles 10-15 as A b C d E F instead of blank.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2,
        DIG_NONE     = 2'd3
    } dig_sel_t;

    // Active-low segments, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ALL   = 7'h00;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        g = SEG_BLANK;
        case (nib)
            4'd0:  g = SEG_0;
            4'd1:  g = SEG_1;
            4'd2:  g = SEG_2;
            4'd3:  g = SEG_3;
            4'd4:  g = SEG_4;
            4'd5:  g = SEG_5;
            4'd6:  g = SEG_6;
            4'd7:  g = SEG_7;
            4'd8:  g = SEG_8;
            4'd9:  g = SEG_9;
`ifdef HEX_GLYPH_EN
            4'd10: g = SEG_A;
            4'd11: g = SEG_B;
            4'd12: g = SEG_C;
            4'd13: g = SEG_D;
            4'd14: g = SEG_E;
            4'd15: g = SEG_F;
`else
            default: g = SEG_BLANK;
`endif
        endcase
        return g;
    endfunction

endpackage

// File: rtl/byte_to_bcd_conv.sv
// Combinational 8-bit binary to 3-digit packed BCD converter (shift-add-3).
module byte_to_bcd_conv
    import bcd_seg_pkg::*;
(
    input  logic [7:0]  value,
    output logic [11:0] bcd
);

    // [19:8] accumulate BCD digits, [7:0] hold the bits still to be shifted in
    logic [19:0] scratch;

    always_comb begin
        scratch = {12'd0, value};
        for (int i = 0; i < 8; i++) begin
            if (scratch[11:8] >= 4'd5)
                scratch[11:8] = scratch[11:8] + 4'd3;
            if (scratch[15:12] >= 4'd5)
                scratch[15:12] = scratch[15:12] + 4'd3;
            if (scratch[19:16] >= 4'd5)
                scratch[19:16] = scratch[19:16] + 4'd3;
            scratch = scratch << 1;
        end
        bcd = scratch[19:8];
    end

endmodule

// File: rtl/bcd_to_seg.sv
// Binary value to registered BCD plus one multiplexed 7-segment digit with LT/RBI/BI controls.
// Nibble 10-15 glyphs depend on HEX_GLYPH_EN (see bcd_seg_pkg).
module bcd_to_seg
    import bcd_seg_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  VALUE,
    input  logic [1:0]  DIG_SEL,
    input  logic        LT_N,
    input  logic        RBI_N,
    input  logic        BI_N,
    output logic [11:0] BCD,
    output logic [6:0]  SEG,
    output logic        RBO_N
);

    logic [11:0] bcd_next;
    logic [3:0]  digit;
    logic        is_none;

    byte_to_bcd_conv u_conv (
        .value (VALUE),
        .bcd   (bcd_next)
    );

    // The segment path decodes the registered BCD, giving VALUE -> SEG two cycles
    always_comb begin
        digit   = 4'd0;
        is_none = 1'b0;
        case (dig_sel_t'(DIG_SEL))
            DIG_ONES:     digit = BCD[3:0];
            DIG_TENS:     digit = BCD[7:4];
            DIG_HUNDREDS: digit = BCD[11:8];
            default:      is_none = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            BCD   <= 12'h000;
            SEG   <= SEG_BLANK;
            RBO_N <= 1'b1;
        end else begin
            BCD <= bcd_next;
            if (!BI_N) begin
                SEG   <= SEG_BLANK;
                RBO_N <= 1'b0;
            end else if (!LT_N) begin
                SEG   <= SEG_ALL;
                RBO_N <= 1'b1;
            end else if (!RBI_N && !is_none && digit == 4'd0) begin
                SEG   <= SEG_BLANK;
                RBO_N <= 1'b0;
            end else if (is_none) begin
                SEG   <= SEG_BLANK;
                RBO_N <= 1'b1;
            end else begin
                SEG   <= glyph(digit);
                RBO_N <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_seg.sv
// Self-checking bench for bcd_to_seg: directed vector table, corner sequences, exhaustive and random runs.
module tb_bcd_to_seg;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [7:0]  VALUE;
    logic [1:0]  DIG_SEL;
    logic        LT_N, RBI_N, BI_N;
    logic [11:0] BCD;
    logic [6:0]  SEG;
    logic        RBO_N;

    int checks   = 0;
    int failures = 0;

    bcd_to_seg dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .VALUE   (VALUE),
        .DIG_SEL (DIG_SEL),
        .LT_N    (LT_N),
        .RBI_N   (RBI_N),
        .BI_N    (BI_N),
        .BCD     (BCD),
        .SEG     (SEG),
        .RBO_N   (RBO_N)
    );

    always #5 CLK = ~CLK;

    logic [6:0] glyph_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                   7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    typedef struct {
        string      name;
        logic [7:0] value;
        logic [1:0] dig;
        logic       lt_n, rbi_n, bi_n;
        logic [11:0] exp_bcd;
        logic [6:0]  exp_seg;
        logic        exp_rbo;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Reference: digit picked arithmetically from the value held in the BCD register
    function automatic void ref_seg(input int held, input int dig, input logic lt_n,
                                    input logic rbi_n, input logic bi_n,
                                    output logic [6:0] seg, output logic rbo);
        int d;
        d = (dig == 0) ? held % 10 : (dig == 1) ? (held / 10) % 10 : held / 100;
        if (!bi_n)                        begin seg = 7'h7F; rbo = 1'b0; end
        else if (!lt_n)                   begin seg = 7'h00; rbo = 1'b1; end
        else if (!rbi_n && dig != 3 && d == 0) begin seg = 7'h7F; rbo = 1'b0; end
        else if (dig == 3)                begin seg = 7'h7F; rbo = 1'b1; end
        else                              begin seg = glyph_tab[d]; rbo = 1'b1; end
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    initial begin
        logic [6:0] e_seg;
        logic       e_rbo;
        int         held;

        RST_N = 1'b0; VALUE = 8'd200; DIG_SEL = 2'd0;
        LT_N = 1'b0; RBI_N = 1'b1; BI_N = 1'b1;

        // Reset holds outputs even with lamp test asserted
        tick(); tick();
        check("reset_bcd", BCD, 12'h000);
        check("reset_seg", {5'd0, SEG}, 12'h07F);
        check("reset_rbo", {11'd0, RBO_N}, 12'h001);
        RST_N = 1'b1; LT_N = 1'b1;
        tick();
        check("release_bcd", BCD, 12'h200);

        vecs.push_back('{"v0",       8'd0,   2'd0, 1'b1, 1'b1, 1'b1, 12'h000, 7'h01, 1'b1});
        vecs.push_back('{"v9",       8'd9,   2'd0, 1'b1, 1'b1, 1'b1, 12'h009, 7'h04, 1'b1});
        vecs.push_back('{"v10",      8'd10,  2'd1, 1'b1, 1'b1, 1'b1, 12'h010, 7'h4F, 1'b1});
        vecs.push_back('{"v99",      8'd99,  2'd0, 1'b1, 1'b1, 1'b1, 12'h099, 7'h04, 1'b1});
        vecs.push_back('{"v100",     8'd100, 2'd2, 1'b1, 1'b1, 1'b1, 12'h100, 7'h4F, 1'b1});
        vecs.push_back('{"v120_h",   8'd120, 2'd2, 1'b1, 1'b1, 1'b1, 12'h120, 7'h4F, 1'b1});
        vecs.push_back('{"v120_t",   8'd120, 2'd1, 1'b1, 1'b1, 1'b1, 12'h120, 7'h12, 1'b1});
        vecs.push_back('{"v120_o",   8'd120, 2'd0, 1'b1, 1'b1, 1'b1, 12'h120, 7'h01, 1'b1});
        vecs.push_back('{"v255_o",   8'd255, 2'd0, 1'b1, 1'b1, 1'b1, 12'h255, 7'h24, 1'b1});
        vecs.push_back('{"v255_blk", 8'd255, 2'd3, 1'b1, 1'b1, 1'b1, 12'h255, 7'h7F, 1'b1});
        vecs.push_back('{"rbi_zero", 8'd5,   2'd2, 1'b1, 1'b0, 1'b1, 12'h005, 7'h7F, 1'b0});
        vecs.push_back('{"rbi_nz",   8'd5,   2'd0, 1'b1, 1'b0, 1'b1, 12'h005, 7'h24, 1'b1});
        vecs.push_back('{"lt_over",  8'd5,   2'd2, 1'b0, 1'b0, 1'b1, 12'h005, 7'h00, 1'b1});
        vecs.push_back('{"bi_over",  8'd5,   2'd2, 1'b0, 1'b0, 1'b0, 12'h005, 7'h7F, 1'b0});
        vecs.push_back('{"v76_t",    8'd76,  2'd1, 1'b1, 1'b1, 1'b1, 12'h076, 7'h0F, 1'b1});
        vecs.push_back('{"v238_t",   8'd238, 2'd1, 1'b1, 1'b1, 1'b1, 12'h238, 7'h06, 1'b1});
        vecs.push_back('{"v168_o",   8'd168, 2'd0, 1'b1, 1'b1, 1'b1, 12'h168, 7'h00, 1'b1});
        vecs.push_back('{"v64_t",    8'd64,  2'd1, 1'b1, 1'b1, 1'b1, 12'h064, 7'h20, 1'b1});

        foreach (vecs[i]) begin
            VALUE = vecs[i].value; DIG_SEL = vecs[i].dig;
            LT_N = vecs[i].lt_n; RBI_N = vecs[i].rbi_n; BI_N = vecs[i].bi_n;
            tick(); tick();
            check({vecs[i].name, "_bcd"}, BCD, vecs[i].exp_bcd);
            check({vecs[i].name, "_seg"}, {5'd0, SEG}, {5'd0, vecs[i].exp_seg});
            check({vecs[i].name, "_rbo"}, {11'd0, RBO_N}, {11'd0, vecs[i].exp_rbo});
        end
        LT_N = 1'b1; RBI_N = 1'b1; BI_N = 1'b1;

        // Two-cycle VALUE -> SEG latency
        VALUE = 8'd0; DIG_SEL = 2'd0;
        tick(); tick();
        check("lat_pre", {5'd0, SEG}, 12'h001);
        VALUE = 8'd88;
        tick();
        check("lat_bcd1", BCD, 12'h088);
        check("lat_seg1", {5'd0, SEG}, 12'h001);
        tick();
        check("lat_seg2", {5'd0, SEG}, 12'h000);

        // VALUE and DIG_SEL change together: new position of old BCD first
        VALUE = 8'd120; DIG_SEL = 2'd0;
        tick(); tick();
        VALUE = 8'd5; DIG_SEL = 2'd2;
        tick();
        check("simul_old", {5'd0, SEG}, 12'h04F);
        tick();
        check("simul_new", {5'd0, SEG}, 12'h001);

        // Mid-operation reset overrides everything
        VALUE = 8'd77; LT_N = 1'b0; RST_N = 1'b0;
        tick();
        check("midrst_bcd", BCD, 12'h000);
        check("midrst_seg", {5'd0, SEG}, 12'h07F);
        RST_N = 1'b1; LT_N = 1'b1;
        tick();
        check("midrst_rel", BCD, 12'h077);

        for (int v = 0; v < 256; v++) begin
            VALUE = 8'(v);
            tick();
            check("exh_bcd", BCD, ref_bcd(v));
        end

        held = 255;
        for (int n = 0; n < 3000; n++) begin
            int dig;
            RST_N   = ($urandom_range(0, 49) != 0);
            VALUE   = 8'($urandom_range(0, 255));
            dig     = int'($urandom_range(0, 3));
            DIG_SEL = 2'(dig);
            LT_N    = ($urandom_range(0, 7) != 0);
            BI_N    = ($urandom_range(0, 7) != 0);
            RBI_N   = (dig == 3) ? 1'b1 : $urandom_range(0, 2) != 0;
            if (!RST_N) begin
                e_seg = 7'h7F; e_rbo = 1'b1; held = 0;
            end else begin
                ref_seg(held, dig, LT_N, RBI_N, BI_N, e_seg, e_rbo);
                held = int'(VALUE);
            end
            tick();
            check("rnd_bcd", BCD, ref_bcd(held));
            check("rnd_seg", {5'd0, SEG}, {5'd0, e_seg});
            check("rnd_rbo", {11'd0, RBO_N}, {11'd0, e_rbo});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
